// File: rtl/input_router_addr_gen.sv
// Expands queued output coordinates into KxK input-window addresses.
// Optional pad flag output: define ADDR_GEN_PAD_FLAG_EN.
module input_router_addr_gen #(
  parameter int ROW_COUNT   = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_o_x,
  input  logic [ADDR_WIDTH-1:0] i_o_y,
  input  logic [ROW_COUNT-1:0]  i_row_id,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic                  i_addr_ready,
  output logic                  o_addr_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ROW_COUNT-1:0]  o_addr_row_id,
  output logic                  o_busy,
`ifdef ADDR_GEN_PAD_FLAG_EN
  output logic                  o_addr_pad,
`endif
  output logic                  o_overflow
);

  localparam int W  = ADDR_WIDTH;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {S_IDLE, S_GEN} state_t;

  state_t r_state, w_nstate;

  logic [W-1:0]         r_qx [QUEUE_DEPTH];
  logic [W-1:0]         r_qy [QUEUE_DEPTH];
  logic [ROW_COUNT-1:0] r_qr [QUEUE_DEPTH];
  logic [PW-1:0]        r_wp, r_rp;
  logic [CW-1:0]        r_cnt;

  logic [W-1:0]         r_x, r_y, r_kx, r_ky, r_addr;
  logic [ROW_COUNT-1:0] r_row;
  logic                 r_valid, r_ovf;

  logic                 w_empty, w_full;
  logic                 w_push, w_pop, w_load, w_adv, w_nvalid;
  logic [W-1:0]         w_k, w_nx, w_ny, w_nkx, w_nky;
  logic [W-1:0]         w_cx, w_cy, w_naddr;
  logic [ROW_COUNT-1:0] w_nrow;
  logic                 w_kx_last, w_ky_last;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(QUEUE_DEPTH));
  assign w_k       = (i_k_size == '0) ? W'(1) : i_k_size;
  assign w_kx_last = (r_kx == w_k - W'(1));
  assign w_ky_last = (r_ky == w_k - W'(1));

  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    w_nvalid = r_valid;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_load   = 1'b1;
          w_nvalid = 1'b1;
          w_nstate = S_GEN;
        end
      end
      S_GEN: begin
        if (i_addr_ready) begin
          if (w_kx_last && w_ky_last) begin
            // chain straight into the next window to avoid a bubble
            if (!w_empty) begin
              w_pop  = 1'b1;
              w_load = 1'b1;
            end else begin
              w_nvalid = 1'b0;
              w_nstate = S_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign w_push = i_en && (!w_full || w_pop);

  assign w_nx   = w_load ? r_qx[r_rp] : r_x;
  assign w_ny   = w_load ? r_qy[r_rp] : r_y;
  assign w_nrow = w_load ? r_qr[r_rp] : r_row;

  always_comb begin
    w_nkx = r_kx;
    w_nky = r_ky;
    if (w_load) begin
      w_nkx = '0;
      w_nky = '0;
    end else if (w_adv) begin
      if (w_kx_last) begin
        w_nkx = '0;
        w_nky = r_ky + W'(1);
      end else begin
        w_nkx = r_kx + W'(1);
      end
    end
  end

  assign w_cx    = w_nx + w_nkx;
  assign w_cy    = w_ny + w_nky;
  assign w_naddr = i_start_addr + w_cy * i_i_size + w_cx;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)          r_state <= S_IDLE;
    else if (i_reg_clear) r_state <= S_IDLE;
    else                  r_state <= w_nstate;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_qx[r_wp] <= i_o_x;
      r_qy[r_wp] <= i_o_y;
      r_qr[r_wp] <= i_row_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_reg_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_en && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_kx    <= '0;
      r_ky    <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else if (i_reg_clear) begin
      r_x     <= '0;
      r_y     <= '0;
      r_kx    <= '0;
      r_ky    <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_nvalid;
      if (w_load || w_adv) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_kx   <= w_nkx;
        r_ky   <= w_nky;
        r_row  <= w_nrow;
        r_addr <= w_naddr;
      end
    end
  end

`ifdef ADDR_GEN_PAD_FLAG_EN
  logic         r_pad;
  logic [W:0]   w_px, w_py;
  logic         w_npad;

  // one extra bit so x+kx past 2^W still counts as out of bounds
  assign w_px   = {1'b0, w_nx} + {1'b0, w_nkx};
  assign w_py   = {1'b0, w_ny} + {1'b0, w_nky};
  assign w_npad = (w_px >= {1'b0, i_i_size}) ||
                  (w_py >= {1'b0, i_i_size});

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                r_pad <= 1'b0;
    else if (i_reg_clear)       r_pad <= 1'b0;
    else if (w_load || w_adv)   r_pad <= w_npad;
  end

  assign o_addr_pad = r_pad;
`endif

  assign o_addr_valid  = r_valid;
  assign o_addr        = r_addr;
  assign o_addr_row_id = r_row;
  assign o_overflow    = r_ovf;
  assign o_busy        = !w_empty || r_valid;

endmodule

// File: tb/tb_input_router_addr_gen.sv
// Bench for input_router_addr_gen: directed cases plus randomized
// windows scored against an arithmetic window model.
module tb_input_router_addr_gen;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int QD = 4;

  logic         clk = 1'b0;
  logic         nrst, clr, en, rdy;
  logic [W-1:0] ox, oy, start, isize, ksize;
  logic [R-1:0] row;
  logic         vld, busy, ovf;
  logic [W-1:0] addr;
  logic [R-1:0] arow;
`ifdef ADDR_GEN_PAD_FLAG_EN
  logic         pad;
`endif

  typedef struct {
    logic [W-1:0] addr;
    logic [R-1:0] row;
    logic         pad;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;
  int   pat = 0;
  int   cyc = 0;
  int   hs_cnt, hs_first, hs_last, pad_cnt;

  always #5 clk = ~clk;

  input_router_addr_gen dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr), .i_en(en),
    .i_o_x(ox), .i_o_y(oy), .i_row_id(row),
    .i_start_addr(start), .i_i_size(isize), .i_k_size(ksize),
    .i_addr_ready(rdy), .o_addr_valid(vld), .o_addr(addr),
    .o_addr_row_id(arow), .o_busy(busy),
`ifdef ADDR_GEN_PAD_FLAG_EN
    .o_addr_pad(pad),
`endif
    .o_overflow(ovf)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int keff();
    return (ksize == 0) ? 1 : int'(ksize);
  endfunction

  function automatic void add_window(int x, int y, int r);
    int   k;
    int   a;
    exp_t e;
    k = keff();
    for (int ky = 0; ky < k; ky++)
      for (int kx = 0; kx < k; kx++) begin
        a = int'(start) + (y + ky) * int'(isize) + (x + kx);
        e.addr = W'(a % 256);
        e.row  = R'(r);
        e.pad  = ((x + kx) >= int'(isize)) || ((y + ky) >= int'(isize));
        q.push_back(e);
      end
  endfunction

  function automatic void clear_stats();
    hs_cnt = 0; hs_first = 0; hs_last = 0; pad_cnt = 0;
  endfunction

  task automatic cycle();
    logic         hold;
    logic [W-1:0] ha;
    exp_t         e;
    case (mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      2:       rdy = (pat % 3 == 0);
      default: rdy = 1'b0;
    endcase
    pat++;
    if (vld && rdy) begin
      hs_cnt++;
      if (hs_cnt == 1) hs_first = cyc;
      hs_last = cyc;
      if (q.size() == 0) begin
        chk("extra_addr", 32'(vld), 0);
      end else begin
        e = q.pop_front();
        chk("addr", 32'(addr), 32'(e.addr));
        chk("row_id", 32'(arow), 32'(e.row));
`ifdef ADDR_GEN_PAD_FLAG_EN
        chk("pad", 32'(pad), 32'(e.pad));
        if (pad) pad_cnt++;
`endif
      end
    end
    hold = vld && !rdy;
    ha   = addr;
    @(posedge clk);
    #1;
    cyc++;
    en = 1'b0;
    if (hold) begin
      chk("hold_valid", 32'(vld), 1);
      chk("hold_addr", 32'(addr), 32'(ha));
    end
  endtask

  task automatic push(int x, int y, int r, bit model);
    ox  = W'(x);
    oy  = W'(y);
    row = R'(r);
    en  = 1'b1;
    if (model) add_window(x, y, r);
    cycle();
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 600 && (busy || q.size() != 0); i++) cycle();
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_left"}, q.size(), 0);
  endtask

  task automatic cfg(int s, int i, int k);
    start = W'(s); isize = W'(i); ksize = W'(k);
  endtask

  initial begin
    int pushed, out;
    nrst = 1'b0; clr = 1'b0; en = 1'b0; rdy = 1'b0;
    ox = '0; oy = '0; row = '0;
    cfg(8'h10, 8, 3);
    #12;
    chk("rst_valid", 32'(vld), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_row", 32'(arow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // single window, continuous ready
    mode = 0; clear_stats();
    push(2, 1, 1, 1);
    chk("lat_t", 32'(vld), 0);
    cycle();
    chk("lat_t1", 32'(vld), 1);
    chk("first_addr", 32'(addr), 32'h1A);
    chk("first_row", 32'(arow), 1);
    for (int i = 0; i < 9; i++) cycle();
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_count", hs_cnt, 9);
    chk("t1_left", q.size(), 0);

    // four back-to-back coordinates, K=2
    cfg(8'h10, 8, 2); clear_stats();
    push(0, 0, 1, 1);
    push(3, 2, 2, 1);
    push(5, 5, 4, 1);
    push(7, 1, 8, 1);
    drain("t2");
    chk("t2_count", hs_cnt, 16);
    chk("t2_nobubble", hs_last - hs_first + 1, 16);
    chk("t2_ovf", 32'(ovf), 0);

    // single window, ready pattern 1,0,0
    cfg(8'h10, 8, 3); clear_stats();
    mode = 2; pat = 0;
    push(2, 1, 1, 1);
    drain("t3");
    chk("t3_count", hs_cnt, 9);

    // overflow: six pushes with ready low
    mode = 3; clear_stats();
    push(1, 1, 1, 1);
    push(2, 2, 2, 1);
    push(3, 3, 4, 1);
    push(4, 4, 8, 1);
    push(5, 5, 1, 1);
    chk("ovf_before", 32'(ovf), 0);
    push(6, 6, 2, 0);
    chk("ovf_set", 32'(ovf), 1);
    mode = 0;
    drain("t4");
    chk("t4_count", hs_cnt, 45);
    chk("ovf_sticky", 32'(ovf), 1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("ovf_clear", 32'(ovf), 0);
    chk("clr_valid", 32'(vld), 0);

    // reset mid-window
    clear_stats();
    push(1, 2, 4, 1);
    for (int i = 0; i < 20 && hs_cnt < 4; i++) cycle();
    chk("t5_reached4", hs_cnt, 4);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vld), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_row", 32'(arow), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    q.delete();
    #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    push(3, 0, 2, 1);
    drain("t5");
    chk("t5_count", hs_cnt, 9);

    // randomized windows and ready
    for (int rnd = 0; rnd < 8; rnd++) begin
      cfg($urandom_range(0, 255), $urandom_range(1, 40),
          $urandom_range(0, 4));
      mode = (rnd % 2 == 0) ? 1 : 0;
      pushed = 0;
      for (int c = 0; c < 800 && (pushed < 10 || busy || q.size() != 0);
           c++) begin
        out = (q.size() + keff() * keff() - 1) / (keff() * keff());
        if (pushed < 10 && out < QD && $urandom_range(0, 2) == 0) begin
          push($urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 15), 1);
          pushed++;
        end else begin
          cycle();
        end
      end
      chk("rnd_pushed", pushed, 10);
      chk("rnd_busy", 32'(busy), 0);
      chk("rnd_left", q.size(), 0);
      chk("rnd_ovf", 32'(ovf), 0);
    end

`ifdef ADDR_GEN_PAD_FLAG_EN
    cfg(0, 4, 3); clear_stats();
    mode = 0;
    push(2, 0, 1, 1);
    drain("pad");
    chk("pad_count", pad_cnt, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_router_addr_gen.md
Name: input_router_addr_gen

Overview:
- Sits directly downstream of the input router controller.
- Consumes the output-feature-map coordinate stream (x, y, row id) that the controller emits while its address-generator enable is high.
- Expands each coordinate into the K×K input-feature-map addresses of its convolution window.
- Streams those addresses, tagged with row id, to the row routers' address buffers through a valid/ready handshake; buffers bursts of coordinates in a small queue.

Parameters:
- ROW_COUNT, 4, number of row routers; width of row id field.
- ADDR_WIDTH, 8, width of coordinates, sizes and addresses.
- QUEUE_DEPTH, 4, coordinate queue entries (power of two, ≥ ROW_COUNT).

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_reg_clear  in  1  synchronous clear; same effect as reset.
- i_en  in  1  coordinate valid; sample i_o_x/i_o_y/i_row_id this edge.
- i_o_x, i_o_y  in  ADDR_WIDTH each  window origin in input space (already stride-scaled).
- i_row_id  in  ROW_COUNT  destination row router id.
- i_start_addr  in  ADDR_WIDTH  base address of input tile.
- i_i_size  in  ADDR_WIDTH  input feature map width (row pitch).
- i_k_size  in  ADDR_WIDTH  kernel side K.
- i_addr_ready  in  1  downstream accepts o_addr this edge.
- o_addr_valid  out  1  o_addr/o_addr_row_id valid.
- o_addr  out  ADDR_WIDTH  generated input address.
- o_addr_row_id  out  ROW_COUNT  row id of the coordinate being expanded.
- o_busy  out  1  queue non-empty or o_addr_valid high.
- o_overflow  out  1  sticky: coordinate dropped on full queue.

Behaviour:
- Reset / i_reg_clear: all outputs 0, queue empty, kx=ky=0, state IDLE. Applies mid-burst; in-flight coordinate and queued entries are discarded.
- Queue: i_en=1 writes {x,y,row_id} at the edge. If full and no pop on that edge, drop the entry and set o_overflow (cleared only by reset/clear). Simultaneous push and pop when full is accepted. No bypass: an entry written at edge t is poppable from edge t+1.
- Address: o_addr = i_start_addr + (y+ky)*i_i_size + (x+kx), truncated mod 2^ADDR_WIDTH. i_k_size=0 is treated as 1. Size and base inputs are static while o_busy=1.
- States:
  - IDLE: if queue non-empty, pop, load x/y/row_id, kx=ky=0, register the first address, o_addr_valid←1, go to GEN.
  - GEN: o_addr_valid and data hold stable until i_addr_ready=1. On handshake, kx++; on kx=K-1, kx←0 and ky++. On the handshake of kx=ky=K-1:
    - if queue non-empty, pop and load the next coordinate the same edge (no bubble);
    - else o_addr_valid←0, go to IDLE.
- Latency: coordinate sampled at edge t when idle and queue empty → first address valid after edge t+1. With continuous ready, K*K addresses on consecutive cycles.
- Order: kx fastest, then ky. Coordinates are processed FIFO.
- o_busy is combinational from the queue count and o_addr_valid.

Optional Feature:
- Macro: ADDR_GEN_PAD_FLAG_EN.
- Defined:
  - extra output o_addr_pad (1 bit), valid with o_addr;
  - o_addr_pad=1 when (x+kx) ≥ i_i_size or (y+ky) ≥ i_i_size, compared at ADDR_WIDTH+1 bits;
  - padded addresses are still emitted, so the count stays K*K.
- Not defined: port absent; no bounds checking.

Test Plan:
- start=0x10, i_size=8, K=3; one coordinate (x=2, y=1, row 1), ready=1.
  - Response: 9 addresses 0x1A,0x1B,0x1C,0x22,0x23,0x24,0x2A,0x2B,0x2C on consecutive cycles.
  - First address valid one cycle after the i_en edge; row_id=1 throughout; o_busy falls after the last.
- Four coordinates pushed on back-to-back cycles (rows 0–3), K=2.
  - Response: 16 addresses, no bubble between windows, correct row ids, o_overflow=0.
- Same as first case with ready toggled 1,0,0,1,…
  - Response: o_addr stable while ready=0; sequence unchanged; no duplicates or skips.
- QUEUE_DEPTH=4, ready=0, push 6 coordinates.
  - Response: first popped, 4 queued, 6th dropped; o_overflow=1 sticky until i_reg_clear.
- Assert i_nrst=0 mid-window (after the 4th address), then release and push a new coordinate.
  - Response: outputs 0 immediately; new window starts at kx=ky=0.
- With ADDR_GEN_PAD_FLAG_EN: i_size=4, K=3, x=2, y=0.
  - Response: o_addr_pad=1 for kx=2 entries only (3 of 9 addresses).
